// File: rtl/tinyalu_arbiter.sv
// rtl/tinyalu_arbiter.sv - round-robin arbiter sharing one TinyALU between NUM_REQ requesters
//
// Purpose: grants one requester at a time (round-robin), drives the ALU start/op/A/B
// pins, waits for alu_done (or a timeout), and returns a one-cycle response pulse
// to the owning requester.
//
// Ports:
//   clk, reset_n            clock (posedge) and asynchronous active-low reset
//   req_valid / req_ready   per-requester command handshake (ready is one-hot or zero)
//   req_a / req_b / req_op  packed per-requester operands (8 bits each) and opcode (3 bits)
//   rsp_valid               one-hot response pulse to the owner
//   rsp_result / rsp_error  16-bit result and error flag, qualified by rsp_valid
//   alu_start / alu_op      ALU command pins
//   alu_a / alu_b           ALU operand pins
//   alu_done / alu_result   ALU completion and result

module tinyalu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 31
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*8-1:0] req_a,
    input  logic [NUM_REQ*8-1:0] req_b,
    input  logic [NUM_REQ*3-1:0] req_op,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [15:0]          rsp_result,
    output logic                 rsp_error,
    output logic                 alu_start,
    output logic [2:0]           alu_op,
    output logic [7:0]           alu_a,
    output logic [7:0]           alu_b,
    input  logic                 alu_done,
    input  logic [15:0]          alu_result
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    logic [PW-1:0] ptr;        // last granted requester; also the owner of the command in flight
    logic [CW-1:0] count;      // cycles alu_start has been high for the current command

    logic          grant_any;
    logic [PW-1:0] grant_idx;
    logic [2:0]    sel_op;
    logic [7:0]    sel_a;
    logic [7:0]    sel_b;

    // Round-robin pick: first valid requester scanning upward from ptr+1 with wrap.
    always_comb begin
        int idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(ptr) + off) % NUM_REQ;
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                grant_idx = PW'(idx);
            end
        end
    end

    assign sel_op = req_op[int'(grant_idx)*3 +: 3];
    assign sel_a  = req_a[int'(grant_idx)*8 +: 8];
    assign sel_b  = req_b[int'(grant_idx)*8 +: 8];

    // The FSM sits in IDLE during reset, so ready is also qualified by reset_n
    // to keep every output low while reset is asserted.
    assign req_ready = (state == IDLE && grant_any && reset_n) ? (NUM_REQ'(1) << grant_idx) : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            ptr        <= PW'(NUM_REQ - 1);
            count      <= '0;
            rsp_valid  <= '0;
            rsp_result <= '0;
            rsp_error  <= 1'b0;
            alu_start  <= 1'b0;
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        ptr <= grant_idx;
                        case (sel_op)
                            OP_ADD, OP_AND, OP_XOR, OP_MUL: begin
                                // ALU pins are only reloaded for real ALU commands so they
                                // hold their last values across no_op / illegal requests.
                                alu_op    <= sel_op;
                                alu_a     <= sel_a;
                                alu_b     <= sel_b;
                                alu_start <= 1'b1;
                                count     <= CW'(1);
                                state     <= BUSY;
                            end
                            OP_NOP: begin
                                rsp_valid  <= NUM_REQ'(1) << grant_idx;
                                rsp_result <= '0;
                                rsp_error  <= 1'b0;
                                state      <= RESP;
                            end
                            default: begin
                                rsp_valid  <= NUM_REQ'(1) << grant_idx;
                                rsp_result <= '0;
                                rsp_error  <= 1'b1;
                                state      <= RESP;
                            end
                        endcase
                    end
                end
                BUSY: begin
                    // done wins over timeout when both land on the same edge
                    if (alu_done) begin
                        rsp_valid  <= NUM_REQ'(1) << ptr;
                        rsp_result <= alu_result;
                        rsp_error  <= 1'b0;
                        alu_start  <= 1'b0;
                        state      <= RESP;
                    end else if (count == CW'(TIMEOUT)) begin
                        rsp_valid  <= NUM_REQ'(1) << ptr;
                        rsp_result <= '0;
                        rsp_error  <= 1'b1;
                        alu_start  <= 1'b0;
                        state      <= RESP;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                RESP: begin
                    rsp_valid  <= '0;
                    rsp_result <= '0;
                    rsp_error  <= 1'b0;
                    count      <= '0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tinyalu_arbiter.sv
// tb/tb_tinyalu_arbiter.sv - self-checking bench for tinyalu_arbiter

module tb_tinyalu_arbiter;

    localparam int N  = 4;
    localparam int TO = 31;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*8-1:0] req_a = '0;
    logic [N*8-1:0] req_b = '0;
    logic [N*3-1:0] req_op = '0;
    logic [N-1:0]   rsp_valid;
    logic [15:0]    rsp_result;
    logic           rsp_error;
    logic           alu_start;
    logic [2:0]     alu_op;
    logic [7:0]     alu_a;
    logic [7:0]     alu_b;
    logic           alu_done = 1'b0;
    logic [15:0]    alu_result = '0;

    tinyalu_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_error(rsp_error),
        .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_done(alu_done), .alu_result(alu_result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // requester side: pending commands held until granted
    bit         pend[N];
    logic [2:0] p_op[N];
    logic [7:0] p_a[N];
    logic [7:0] p_b[N];
    int         p_dly[N];    // ALU latency for this command, 0 = never done
    bit         gen_en = 1'b0;

    // transaction-timeline model
    int          ptr_m, free_at, start_lo, start_hi, rsp_at, m_owner, cur_delay;
    logic [15:0] m_res;
    bit          m_err;
    logic [2:0]  m_op;
    logic [7:0]  m_a, m_b;

    // observations of the DUT used by the directed literal checks
    int          start_run = 0, low_run = 0;
    int          runs_log[$];
    int          gaps_log[$];
    int          grant_log[$];
    logic [15:0] res_by[N];
    bit          err_by[N];
    int          acc_cyc[N], rsp_cyc[N];
    logic [N-1:0] last_rsp_vec = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd1: return {8'd0, a} + {8'd0, b};
            3'd2: return {8'd0, a & b};
            3'd3: return {8'd0, a ^ b};
            3'd4: return {8'd0, a} * {8'd0, b};
            default: return 16'd0;
        endcase
    endfunction

    function automatic int pick();
        int j;
        for (int off = 1; off <= N; off++) begin
            j = (ptr_m + off) % N;
            if (pend[j]) return j;
        end
        return -1;
    endfunction

    function automatic bit any_pend();
        for (int i = 0; i < N; i++) if (pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        ptr_m = N - 1; free_at = cyc; start_lo = 1; start_hi = 0; rsp_at = -1;
        m_owner = 0; m_op = '0; m_a = '0; m_b = '0; cur_delay = 0;
    endtask

    task automatic post(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input int dly);
        pend[i] = 1'b1; p_op[i] = op; p_a[i] = a; p_b[i] = b; p_dly[i] = dly;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]      = pend[i];
            req_op[i*3 +: 3]  = p_op[i];
            req_a[i*8 +: 8]   = p_a[i];
            req_b[i*8 +: 8]   = p_b[i];
        end
    endtask

    task automatic compare();
        logic [N-1:0] e_ready, e_rsp;
        int g, k;
        g = pick();
        e_ready = (cyc >= free_at && g >= 0) ? (N'(1) << g) : '0;
        chk("req_ready", req_ready, e_ready);
        chk("alu_start", alu_start, (cyc >= start_lo && cyc <= start_hi));
        chk("alu_op", alu_op, m_op);
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
        e_rsp = (cyc == rsp_at) ? (N'(1) << m_owner) : '0;
        chk("rsp_valid", rsp_valid, e_rsp);
        if (e_rsp != 0) begin
            chk("rsp_result", rsp_result, m_res);
            chk("rsp_error", rsp_error, m_err);
        end
        if (rsp_valid != 0) begin
            last_rsp_vec = rsp_valid;
            for (int i = 0; i < N; i++)
                if (rsp_valid[i]) begin res_by[i] = rsp_result; err_by[i] = rsp_error; rsp_cyc[i] = cyc; end
        end
        for (int i = 0; i < N; i++)
            if (req_valid[i] && req_ready[i]) begin grant_log.push_back(i); acc_cyc[i] = cyc; end
        if (e_ready != 0) begin
            pend[g] = 1'b0; ptr_m = g; m_owner = g;
            if (p_op[g] >= 3'd1 && p_op[g] <= 3'd4) begin
                k = (p_dly[g] == 0 || p_dly[g] > TO) ? TO : p_dly[g];
                start_lo = cyc + 1; start_hi = cyc + k; rsp_at = cyc + k + 1; free_at = cyc + k + 2;
                m_op = p_op[g]; m_a = p_a[g]; m_b = p_b[g]; cur_delay = p_dly[g];
                m_err = (k != p_dly[g]);
                m_res = m_err ? 16'd0 : alu_fn(p_op[g], p_a[g], p_b[g]);
            end else begin
                rsp_at = cyc + 1; free_at = cyc + 2; m_res = 16'd0; m_err = (p_op[g] != 3'd0);
            end
        end
    endtask

    task automatic step_body();
        int d;
        logic [2:0] op;
        if (alu_start) begin
            if (start_run == 0) gaps_log.push_back(low_run);
            start_run++; low_run = 0;
            alu_done   = (cur_delay != 0 && start_run == cur_delay);
            alu_result = alu_done ? alu_fn(alu_op, alu_a, alu_b) : 16'($urandom);
        end else begin
            if (start_run > 0) runs_log.push_back(start_run);
            start_run = 0; low_run++;
            alu_done   = ($urandom_range(7) == 0);
            alu_result = 16'($urandom);
        end
        if (gen_en) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(3) == 0) begin
                    op = 3'($urandom_range(7));
                    if (op >= 3'd5 && $urandom_range(1) == 0) op = op - 3'd4;
                    d = $urandom_range(19);
                    d = (d == 0) ? 0 : (d == 1) ? TO : (d == 2) ? TO + 3 : 1 + d % 5;
                    post(i, op, 8'($urandom), 8'($urandom), d);
                end
            end
        end
        drive();
        #1;
        compare();
    endtask

    task automatic step();
        @(negedge clk);
        step_body();
    endtask

    task automatic run_idle(input int maxc);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < maxc; n++) begin
            step();
            if (!any_pend() && cyc >= free_at) begin ok = 1'b1; break; end
        end
        chk("run_idle_bound", ok, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_result"}, rsp_result, 0);
        chk({tag, "_rsp_error"}, rsp_error, 0);
        chk({tag, "_alu_start"}, alu_start, 0);
        chk({tag, "_alu_op"}, alu_op, 0);
        chk({tag, "_alu_a"}, alu_a, 0);
        chk({tag, "_alu_b"}, alu_b, 0);
    endtask

    initial begin
        int r0, g0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 0; p_op[i] = 0; p_a[i] = 0; p_b[i] = 0; p_dly[i] = 0;
            res_by[i] = 0; err_by[i] = 0; acc_cyc[i] = 0; rsp_cyc[i] = 0;
        end
        model_reset();

        // reset state, with a valid request present
        post(1, 3'd1, 8'd1, 8'd1, 1);
        drive();
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        pend[1] = 0;
        drive();
        reset_n = 1'b1;
        model_reset();
        step_body();

        // all four valid after reset -> 0,1,2,3; then 0 and 2 -> 0,2
        post(0, 3'd1, 8'd1, 8'd1, 1);
        post(1, 3'd0, 8'd7, 8'd7, 1);
        post(2, 3'd2, 8'h0F, 8'h03, 2);
        post(3, 3'd6, 8'd0, 8'd0, 1);
        run_idle(100);
        post(0, 3'd3, 8'h55, 8'hAA, 1);
        post(2, 3'd1, 8'd200, 8'd100, 1);
        run_idle(100);
        chk("grant_count", grant_log.size(), 6);
        if (grant_log.size() == 6) begin
            chk("grant0", grant_log[0], 0);
            chk("grant1", grant_log[1], 1);
            chk("grant2", grant_log[2], 2);
            chk("grant3", grant_log[3], 3);
            chk("grant4", grant_log[4], 0);
            chk("grant5", grant_log[5], 2);
        end
        chk("add_200_100", res_by[2], 16'd300);

        // req0 3+5, done after 1 cycle
        post(0, 3'd1, 8'd3, 8'd5, 1);
        run_idle(100);
        chk("t1_vec", last_rsp_vec, 4'b0001);
        chk("t1_result", res_by[0], 16'd8);
        chk("t1_error", err_by[0], 0);

        // req1 255*255 done after 3, req3 waiting behind it
        r0 = runs_log.size(); g0 = gaps_log.size();
        post(1, 3'd4, 8'd255, 8'd255, 3);
        post(3, 3'd1, 8'd1, 8'd2, 1);
        run_idle(100);
        chk("mul_result", res_by[1], 16'hFE01);
        chk("mul_error", err_by[1], 0);
        chk("mul_start_len", (runs_log.size() > r0) ? runs_log[r0] : -1, 3);
        chk("start_gap_ge2", (gaps_log.size() > g0 + 1) ? (gaps_log[g0+1] >= 2) : 0, 1);
        chk("t3_second", res_by[3], 16'd3);

        // no_op and illegal
        r0 = runs_log.size(); g0 = gaps_log.size();
        post(2, 3'd0, 8'd9, 8'd9, 1);
        run_idle(100);
        chk("nop_result", res_by[2], 0);
        chk("nop_error", err_by[2], 0);
        chk("nop_latency", rsp_cyc[2] - acc_cyc[2], 1);
        post(3, 3'b111, 8'd4, 8'd4, 1);
        run_idle(100);
        chk("ill_result", res_by[3], 0);
        chk("ill_error", err_by[3], 1);
        chk("no_start_nop_ill", gaps_log.size() - g0, 0);

        // ALU never finishes -> timeout; next request served
        post(0, 3'd1, 8'd9, 8'd9, 0);
        run_idle(100);
        chk("to_start_len", (runs_log.size() > 0) ? runs_log[runs_log.size()-1] : -1, 31);
        chk("to_error", err_by[0], 1);
        chk("to_result", res_by[0], 0);
        post(1, 3'd3, 8'hF0, 8'h3C, 2);
        run_idle(100);
        chk("after_to_result", res_by[1], 16'h00CC);

        // randomized traffic
        gen_en = 1'b1;
        repeat (3000) step();
        gen_en = 1'b0;
        run_idle(1000);

        // reset in the middle of a mul, with req0 and req3 pending
        post(1, 3'd4, 8'd12, 8'd34, 0);
        repeat (6) step();
        chk("pre_reset_busy", alu_start, 1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        post(0, 3'd1, 8'd10, 8'd20, 1);
        post(3, 3'd2, 8'hFF, 8'h0F, 1);
        drive();
        #1;
        chk_all_zero("async_reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        grant_log.delete();
        step_body();
        run_idle(100);
        chk("rst_grant_count", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            chk("rst_grant0", grant_log[0], 0);
            chk("rst_grant1", grant_log[1], 3);
        end
        chk("rst_res0", res_by[0], 16'd30);
        chk("rst_res3", res_by[3], 16'h000F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
